// File: rtl/voice_mixer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : voice_mixer_pkg
//  Description : Shared types and constants for the voice mixer: waveform
//                select encoding, noise LFSR geometry and the accumulator
//                width helper used to size the mixing sum.
//  Revision    : 1.0 - initial release
// ============================================================================
package voice_mixer_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_TRI    = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_NOISE  = 2'd3
    } wave_e;

    // 15-bit Fibonacci LFSR, polynomial x^15 + x^14 + 1.
    localparam int c_lfsr_w      = 15;
    localparam int c_lfsr_tap_hi = 14;
    localparam int c_lfsr_tap_lo = 13;
    // Channel i is seeded with c_lfsr_seed_base + i so no channel starts at 0.
    localparam int c_lfsr_seed_base = 1;

    // Width that holds the sum of num contributions of (pw+v) bits each.
    function automatic int acc_width(input int pw, input int v, input int num);
        return pw + v + $clog2(num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_mixer_osc.sv
`default_nettype none
// ============================================================================
//  Module      : voice_osc
//  Description : One voice channel. Pitch divider advancing a PW-bit phase,
//                waveform shaping (square / triangle / saw / noise) and
//                linear volume scaling. The contribution is zero while the
//                channel is disabled, and the divider, phase and LFSR sit at
//                their reset values so a re-enabled voice restarts at phase 0.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_tick          - prescaler strobe, advances the divider
//                i_ena           - channel enable
//                i_pitch         - divider terminal count
//                i_wave          - waveform select (wave_e encoding)
//                i_volume        - linear gain, 0 mutes
//                o_contrib       - wave * volume, PW+V bits unsigned
//  Options     : VOICE_MIXER_NOISE_EN builds the noise LFSR; without it the
//                noise selection produces the square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_osc
    import voice_mixer_pkg::*;
#(
    parameter int C  = 14,
    parameter int PW = 7,
`ifdef VOICE_MIXER_NOISE_EN
    parameter logic [c_lfsr_w-1:0] SEED = 15'd1,
`endif
    parameter int V  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_tick,
    input  logic            i_ena,
    input  logic [C-1:0]    i_pitch,
    input  logic [1:0]      i_wave,
    input  logic [V-1:0]    i_volume,
    output logic [PW+V-1:0] o_contrib
);

    logic [C-1:0]  r_div;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_sample;
    logic [PW-1:0] w_square;
    logic [PW-1:0] w_tri;
    logic          w_advance;

    // >= rather than == so a pitch lowered below the running count wraps at
    // the very next tick instead of counting all the way round.
    assign w_advance = i_tick && (r_div >= i_pitch);

    always_ff @(posedge clk) begin
        if (rst || !i_ena) begin
            r_div   <= '0;
            r_phase <= '0;
        end else if (i_tick) begin
            if (w_advance) begin
                r_div   <= '0;
                r_phase <= r_phase + PW'(1);
            end else begin
                r_div   <= r_div + C'(1);
            end
        end
    end

    assign w_square = {PW{r_phase[PW-1]}};
    assign w_tri    = {(r_phase[PW-1] ? ~r_phase[PW-2:0] : r_phase[PW-2:0]), 1'b0};

`ifdef VOICE_MIXER_NOISE_EN
    logic [c_lfsr_w-1:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (rst || !i_ena) begin
            r_lfsr <= SEED;
        end else if (w_advance) begin
            r_lfsr <= {r_lfsr[c_lfsr_w-2:0], r_lfsr[c_lfsr_tap_hi] ^ r_lfsr[c_lfsr_tap_lo]};
        end
    end

    always_comb begin
        w_sample = w_square;
        case (i_wave)
            WAVE_SQUARE: w_sample = w_square;
            WAVE_TRI:    w_sample = w_tri;
            WAVE_SAW:    w_sample = r_phase;
            WAVE_NOISE:  w_sample = r_lfsr[PW-1:0];
            default:     w_sample = w_square;
        endcase
    end
`else
    always_comb begin
        w_sample = w_square;
        case (i_wave)
            WAVE_TRI: w_sample = w_tri;
            WAVE_SAW: w_sample = r_phase;
            default:  w_sample = w_square;
        endcase
    end
`endif

    assign o_contrib = i_ena ? ((PW+V)'(w_sample) * (PW+V)'(i_volume)) : '0;

endmodule
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : voice_mixer
//  Description : NUM-voice synth mixer. A shared prescaler clocks the voice
//                dividers; a time-multiplexed accumulator adds one channel per
//                clock and, after the last channel, scales the sum into a
//                W-bit unsigned sample with a one-cycle valid strobe.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                pitches         - channel i pitch at [C*i +: C]
//                channel_ena     - per-channel enable
//                waveforms       - channel i waveform at [2*i +: 2]
//                volumes         - channel i volume at [V*i +: V]
//                audio           - mixed sample, held between strobes
//                sample_valid    - one-cycle pulse when audio updates
//  Options     : VOICE_MIXER_NOISE_EN enables the per-channel noise voice.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int NUM = 4,
    parameter int M   = 0,
    parameter int C   = 14,
    parameter int PW  = 7,
    parameter int V   = 4,
    parameter int W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM*C-1:0] pitches,
    input  logic [NUM-1:0]   channel_ena,
    input  logic [NUM*2-1:0] waveforms,
    input  logic [NUM*V-1:0] volumes,
    output logic [W-1:0]     audio,
    output logic             sample_valid
);

    localparam int A  = acc_width(PW, V, NUM);
    localparam int KW = (NUM > 1) ? $clog2(NUM) : 1;

    logic                w_tick;
    logic [PW+V-1:0]     w_contrib [NUM];
    logic [PW+V-1:0]     w_sel;
    logic [A-1:0]        w_sum;
    logic [W-1:0]        w_scaled;
    logic                w_last;
    logic [A-1:0]        r_acc;
    logic [KW-1:0]       r_k;
    logic [W-1:0]        r_audio;
    logic                r_valid;

    // Prescaler: tick on the cycle the counter is about to wrap.
    if (M > 0) begin : g_presc
        logic [M-1:0] r_presc;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + M'(1);
            end
        end
        assign w_tick = &r_presc;
    end else begin : g_no_presc
        assign w_tick = 1'b1;
    end

    for (genvar i = 0; i < NUM; i++) begin : g_osc
        voice_osc #(
            .C    (C),
            .PW   (PW),
`ifdef VOICE_MIXER_NOISE_EN
            .SEED (c_lfsr_w'(c_lfsr_seed_base + i)),
`endif
            .V    (V)
        ) u_osc (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (w_tick),
            .i_ena     (channel_ena[i]),
            .i_pitch   (pitches[C*i +: C]),
            .i_wave    (waveforms[2*i +: 2]),
            .i_volume  (volumes[V*i +: V]),
            .o_contrib (w_contrib[i])
        );
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM; i++) begin
            if (r_k == KW'(i)) begin
                w_sel = w_contrib[i];
            end
        end
    end

    assign w_sum  = r_acc + A'(w_sel);
    assign w_last = (r_k == KW'(NUM-1));

    // Keep the top W bits of the sum; pad with zeros when the sum is narrower.
    if (A >= W) begin : g_scale_trunc
        assign w_scaled = w_sum[A-1 -: W];
    end else begin : g_scale_pad
        assign w_scaled = {w_sum, {(W-A){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_k     <= '0;
            r_audio <= '0;
            r_valid <= 1'b0;
        end else if (w_last) begin
            r_acc   <= '0;
            r_k     <= '0;
            r_audio <= w_scaled;
            r_valid <= 1'b1;
        end else begin
            r_acc   <= w_sum;
            r_k     <= r_k + KW'(1);
            r_valid <= 1'b0;
        end
    end

    assign audio        = r_audio;
    assign sample_valid = r_valid;

endmodule
`default_nettype wire
